// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece controller.
// Provides state/direction enums plus board and spawn geometry.
package tetris_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT,
        APPLY,
        LOCK,
        WAIT_SPAWN
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT,
        DIR_RIGHT,
        DIR_DOWN
    } dir_t;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 16;

    localparam logic [3:0] DEF_SPAWN_X = 4'd4;
    localparam logic [4:0] DEF_SPAWN_Y = 5'd0;
    localparam logic [4:0] DEF_Y_MAX   = 5'd16;

endpackage

// File: rtl/piece_move_ctrl_rise_pulse.sv
// 1-bit rising-edge detector with async reset.
// Ports: clk, rst, d (level in), pulse (high while d=1 and last d=0).
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= d;
    end

    assign pulse = d & ~prev;

endmodule

// File: rtl/piece_move_ctrl.sv
// Falling-piece movement controller: move/gravity requests -> checker
// enables, then commits XPOS/YPOS or locks. Ports: clk, rst, moveLeft,
// moveRight, dropTick, spawn, canMove*, en*, XPOS, YPOS, pieceLocked, busy.
module piece_move_ctrl
    import tetris_pkg::*;
#(
    parameter logic [3:0] SPAWN_X = DEF_SPAWN_X,
    parameter logic [4:0] SPAWN_Y = DEF_SPAWN_Y,
    parameter logic [4:0] Y_MAX   = DEF_Y_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       moveLeft,
    input  logic       moveRight,
    input  logic       dropTick,
    input  logic       spawn,
    input  logic       canMoveLeft,
    input  logic       canMoveRight,
    input  logic       canMoveDown,
    output logic       enLeft,
    output logic       enRight,
    output logic       enDown,
    output logic [3:0] XPOS,
    output logic [4:0] YPOS,
    output logic       pieceLocked,
    output logic       busy
);

    logic left_edge, right_edge;

    rise_pulse u_left (
        .clk   (clk),
        .rst   (rst),
        .d     (moveLeft),
        .pulse (left_edge)
    );

    rise_pulse u_right (
        .clk   (clk),
        .rst   (rst),
        .d     (moveRight),
        .pulse (right_edge)
    );

    state_t     state, next_state;
    dir_t       dir, next_dir;
    logic       pending, next_pending;
    logic [3:0] next_x;
    logic [4:0] next_y;

    logic en_left_d, en_right_d, en_down_d;
    logic locked_d, busy_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dir     <= DIR_LEFT;
            pending <= 1'b0;
            XPOS    <= SPAWN_X;
            YPOS    <= SPAWN_Y;
        end else begin
            state   <= next_state;
            dir     <= next_dir;
            pending <= next_pending;
            XPOS    <= next_x;
            YPOS    <= next_y;
        end
    end

    // Next-state and position update
    always_comb begin
        next_state   = state;
        next_dir     = dir;
        next_pending = pending;
        next_x       = XPOS;
        next_y       = YPOS;

        // Gravity must not be lost while a move is in flight
        if (dropTick && state != IDLE && state != WAIT_SPAWN)
            next_pending = 1'b1;

        case (state)
            IDLE: begin
                if (dropTick || pending) begin
                    next_dir     = DIR_DOWN;
                    next_pending = 1'b0;
                    next_state   = CHECK;
                end else if (left_edge ^ right_edge) begin
                    next_dir   = left_edge ? DIR_LEFT : DIR_RIGHT;
                    next_state = CHECK;
                end
            end
            CHECK: next_state = WAIT;
            WAIT:  next_state = APPLY;
            APPLY: begin
                next_state = IDLE;
                case (dir)
                    DIR_LEFT:
                        if (canMoveLeft && XPOS != 4'd0)
                            next_x = XPOS - 4'd1;
                    DIR_RIGHT:
                        if (canMoveRight && XPOS != 4'd15)
                            next_x = XPOS + 4'd1;
                    DIR_DOWN:
                        if (canMoveDown && YPOS < Y_MAX)
                            next_y = YPOS + 5'd1;
                        else
                            next_state = LOCK;
                    default: next_state = IDLE;
                endcase
            end
            LOCK: begin
                next_pending = 1'b0;
                next_state   = WAIT_SPAWN;
            end
            WAIT_SPAWN: begin
                next_pending = 1'b0;
                if (spawn) begin
                    next_x     = SPAWN_X;
                    next_y     = SPAWN_Y;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they can be registered
    always_comb begin
        en_left_d  = (next_state == CHECK) && (next_dir == DIR_LEFT);
        en_right_d = (next_state == CHECK) && (next_dir == DIR_RIGHT);
        en_down_d  = (next_state == CHECK) && (next_dir == DIR_DOWN);
        locked_d   = (next_state == LOCK);
        busy_d     = (next_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enLeft      <= 1'b0;
            enRight     <= 1'b0;
            enDown      <= 1'b0;
            pieceLocked <= 1'b0;
            busy        <= 1'b0;
        end else begin
            enLeft      <= en_left_d;
            enRight     <= en_right_d;
            enDown      <= en_down_d;
            pieceLocked <= locked_d;
            busy        <= busy_d;
        end
    end

endmodule
